// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response and Storage-side signals of the
// two-port memory arbiter. The slave modport is the arbiter's view. The
// master modport is the view of the requesters and the Storage.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]             req_valid;
  logic [1:0]             req_we;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             req_ready;
  logic [1:0]             rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_we;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported data Storage between
// instruction fetch (port 0) and load/store (port 1). At most one request
// is granted per cycle. Read data returns one cycle after the handshake.
//
// Build option MEM_PORT_ARB_RR_EN: strict round-robin with a 1-bit
// preference pointer. Without it, port 1 has fixed priority, and a 2-bit
// starvation counter lets port 0 through after three consecutive losses.
module mem_port_arbiter #(
  parameter int NPORTS = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  if (NPORTS != 2) begin : g_nports_check
    $error("mem_port_arbiter supports exactly two ports");
  end

  logic [1:0] vld;
  logic       gnt_any;
  logic       gnt_port;
  logic       rsp_pend;
  logic       rsp_port;

  // Requests are ignored while reset is held.
  assign vld     = rst ? 2'b00 : bus.req_valid;
  assign gnt_any = |vld;

`ifdef MEM_PORT_ARB_RR_EN
  logic rr_ptr;

  // Pick the preferred port on contention; otherwise pick the lone requester.
  always_comb begin
    gnt_port = vld[1];
    if (vld == 2'b11) gnt_port = rr_ptr;
  end

  // After every grant, preference passes to the other port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rr_ptr <= 1'b0;
    else if (gnt_any) rr_ptr <= ~gnt_port;
  end
`else
  logic [1:0] starve_cnt;

  // Port 1 wins contention unless port 0 has already lost three times.
  always_comb begin
    gnt_port = vld[1];
    if (vld == 2'b11) gnt_port = (starve_cnt != 2'd3);
  end

  // Count port-1 grants that made port 0 wait. Any port-0 grant clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 2'd0;
    end else if (gnt_any) begin
      if (!gnt_port)   starve_cnt <= 2'd0;
      else if (vld[0]) starve_cnt <= starve_cnt + 2'd1;
    end
  end
`endif

  // Route the granted request to Storage. Drive zeros when idle.
  always_comb begin
    bus.req_ready = 2'b00;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_any) begin
      bus.req_ready[gnt_port] = 1'b1;
      bus.mem_we              = bus.req_we[gnt_port];
      bus.mem_addr            = bus.req_addr[gnt_port];
      bus.mem_wdata           = bus.req_wdata[gnt_port];
    end
  end

  // A granted read owes its port a response in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pend <= 1'b0;
      rsp_port <= 1'b0;
    end else begin
      rsp_pend <= gnt_any & ~bus.req_we[gnt_port];
      if (gnt_any) rsp_port <= gnt_port;
    end
  end

  // Storage already holds the read word. Pass it through only while a
  // response is pending.
  always_comb begin
    bus.rsp_valid = 2'b00;
    bus.rsp_data  = '0;
    if (rsp_pend) begin
      bus.rsp_valid[rsp_port] = 1'b1;
      bus.rsp_data            = bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus against mem_port_arbiter with a
// behavioural Storage and a cycle-by-cycle reference model of grants,
// memory contents and responses.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.NPORTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'hA50000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural Storage: writes commit at the edge; read_out holds on write edges.
  logic [31:0] store   [256];
  logic        written [256];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      store[bus.mem_addr[7:0]]   <= bus.mem_wdata;
      written[bus.mem_addr[7:0]] <= 1'b1;
    end else begin
      bus.mem_rdata <= (written[bus.mem_addr[7:0]] === 1'b1) ?
                       store[bus.mem_addr[7:0]] : init_val(bus.mem_addr[7:0]);
    end
  end

  // Reference model state and the logs used by the literal checks.
  logic        log_en = 1'b0;
  int          gnt_log[$];
  logic        tp_en = 1'b0;
  int          tp_cnt = 0;

  initial begin
    logic [31:0] shadow [256];
    logic        m_pend;
    int          m_port;
    logic [31:0] m_data;
    int          m_starve;
    int          m_pref;
    logic [1:0]  v;
    logic        g;
    int          w;
    logic [1:0]  e_ready;
    logic [1:0]  e_rv;

    for (int i = 0; i < 256; i++) shadow[i] = init_val(i[7:0]);
    m_pend = 1'b0; m_port = 0; m_data = '0; m_starve = 0; m_pref = 0;

    forever begin
      @(negedge clk);
      if (rst) begin
        m_pend = 1'b0; m_starve = 0; m_pref = 0;
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rst_rsp_data",  bus.rsp_data,  32'h0);
        chk("rst_mem_we",    bus.mem_we,    1'b0);
        chk("rst_mem_addr",  bus.mem_addr,  32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      end else begin
        v = bus.req_valid;
        g = (v != 2'b00);
        if (v == 2'b11) begin
`ifdef MEM_PORT_ARB_RR_EN
          w = m_pref;
`else
          w = (m_starve >= 3) ? 0 : 1;
`endif
        end else begin
          w = v[1] ? 1 : 0;
        end

        e_ready = g ? (2'b01 << w) : 2'b00;
        e_rv    = m_pend ? (2'b01 << m_port) : 2'b00;
        chk("req_ready", bus.req_ready, e_ready);
        chk("mem_we",    bus.mem_we,    g ? bus.req_we[w] : 1'b0);
        chk("mem_addr",  bus.mem_addr,  g ? bus.req_addr[w] : 32'h0);
        chk("mem_wdata", bus.mem_wdata, g ? bus.req_wdata[w] : 32'h0);
        chk("rsp_valid", bus.rsp_valid, e_rv);
        chk("rsp_data",  bus.rsp_data,  m_pend ? m_data : 32'h0);

        if (log_en && bus.req_ready != 2'b00) gnt_log.push_back(bus.req_ready[1] ? 1 : 0);
        if (tp_en && bus.rsp_valid == 2'b01) tp_cnt++;

        // Advance the model by one clock edge.
        m_pend = g && !bus.req_we[w];
        if (g) begin
          m_port = w;
          if (bus.req_we[w]) shadow[bus.req_addr[w][7:0]] = bus.req_wdata[w];
          else               m_data = shadow[bus.req_addr[w][7:0]];
          m_pref = 1 - w;
          if (w == 0)     m_starve = 0;
          else if (v[0])  m_starve = m_starve + 1;
        end
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge; return after the
  // model has checked that cycle.
  task automatic cyc(input logic r, input logic [1:0] v, input logic [1:0] we,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1);
    @(posedge clk);
    #1;
    rst              = r;
    bus.req_valid    = v;
    bus.req_we       = we;
    bus.req_addr[0]  = a0;
    bus.req_addr[1]  = a1;
    bus.req_wdata[0] = d0;
    bus.req_wdata[1] = d1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  int exp_g [8];

  initial begin
`ifdef MEM_PORT_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_g = '{1, 1, 1, 0, 1, 1, 1, 0};
`endif
    bus.req_valid = 2'b11; bus.req_we = 2'b00;
    bus.req_addr[0] = 32'h10; bus.req_addr[1] = 32'h20;
    bus.req_wdata[0] = 32'h0; bus.req_wdata[1] = 32'h0;

    // Reset held with both ports requesting.
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0);
    chk("lit_rst_ready", bus.req_ready, 2'b00);
    chk("lit_rst_rv",    bus.rsp_valid, 2'b00);

    // First read after reset.
    cyc(1'b0, 2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
    chk("lit_first_ready", bus.req_ready, 2'b01);
    idle();
    chk("lit_first_rv",   bus.rsp_valid, 2'b01);
    chk("lit_first_data", bus.rsp_data,  32'hDEADBEEF);

    // Port 1 writes, then reads the same word back.
    cyc(1'b0, 2'b10, 2'b10, 32'h0, 32'h20, 32'h0, 32'h12345678);
    chk("lit_wr_we", bus.mem_we, 1'b1);
    cyc(1'b0, 2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0);
    chk("lit_rd_we", bus.mem_we, 1'b0);
    idle();
    chk("lit_wr_rd_rv",   bus.rsp_valid, 2'b10);
    chk("lit_wr_rd_data", bus.rsp_data,  32'h12345678);

    // Fresh reset, then eight cycles of contention.
    cyc(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    gnt_log.delete();
    log_en = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'b11, 2'b00, 32'h1, 32'h2, 32'h0, 32'h0);
    log_en = 1'b0;
    idle();
    chk("lit_cont_count", gnt_log.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("lit_cont_gnt%0d", i),
                                    (i < gnt_log.size()) ? gnt_log[i] : -1, exp_g[i]);

    // Reset asserted while a read response is pending.
    cyc(1'b0, 2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
    cyc(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("lit_midrst_rv", bus.rsp_valid, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    cyc(1'b0, 2'b01, 2'b00, 32'h3, 32'h0, 32'h0, 32'h0);
    idle();
    chk("lit_postrst_rv",   bus.rsp_valid, 2'b01);
    chk("lit_postrst_data", bus.rsp_data,  32'hA5000003);

    // Back-to-back reads from port 0 at full throughput.
    tp_cnt = 0;
    tp_en  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 2'b01, 2'b00, i, 32'h0, 32'h0, 32'h0);
      if (i > 0) chk($sformatf("lit_tp_rv%0d", i), bus.rsp_valid, 2'b01);
    end
    idle();
    chk("lit_tp_rv_last", bus.rsp_valid, 2'b01);
    tp_en = 1'b0;
    chk("lit_tp_pulses", tp_cnt, 8);

    // Same-word read/write contention, then a read followed by a write.
    cyc(1'b0, 2'b11, 2'b10, 32'h40, 32'h40, 32'h0, 32'hCAFEF00D);
    cyc(1'b0, 2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0);
    cyc(1'b0, 2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0);
    cyc(1'b0, 2'b10, 2'b10, 32'h0, 32'h21, 32'h0, 32'h55AA55AA);
    chk("lit_rw_rv",   bus.rsp_valid, 2'b10);
    chk("lit_rw_data", bus.rsp_data,  32'h12345678);
    cyc(1'b0, 2'b01, 2'b00, 32'h21, 32'h0, 32'h0, 32'h0);
    idle();
    chk("lit_rw_readback", bus.rsp_data, 32'h55AA55AA);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
